register_file: RTL and testbench
================================

Name: register_file

Overview:
- 16-entry x 16-bit general-purpose register file for the CPU datapath.
- Two asynchronous read ports and one synchronous write port.
- Byte-lane write modes support the load-low-byte (LLB) and load-high-byte (LHB) instructions.
- Sits between decode (register specifiers) and writeback (result data).

Parameters:
- DATA_W, 16, register width in bits; byte modes act on [7:0] and [15:8].
- NUM_REGS, 16, number of registers; register specifiers are log2(NUM_REGS) = 4 bits.

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all registers.
- SrcReg1  input  4  read port 1 register specifier.
- SrcReg2  input  4  read port 2 register specifier.
- DstReg  input  4  write register specifier.
- WriteReg  input  1  write enable.
- writedata  input  16  write data.
- LLB  input  1  load-low-byte write mode.
- LHB  input  1  load-high-byte write mode.
- SrcData1  output  16  read data for SrcReg1.
- SrcData2  output  16  read data for SrcReg2.

Behaviour:
- Reset: while rst=1, all 16 registers are 0x0000, independent of clk. SrcData1/2 therefore read 0x0000.
- Write occurs on a clk rising edge when rst=0 and WriteReg=1. The new value depends on the mode:
  - LLB=1: reg[DstReg] = {reg[DstReg][15:8], writedata[7:0]}.
  - LLB=0, LHB=1: reg[DstReg] = {writedata[7:0], reg[DstReg][7:0]}.
  - LLB=0, LHB=0: reg[DstReg] = writedata (full word).
  - LLB=1 and LHB=1 together: LLB takes priority; LHB is ignored.
- WriteReg=0: no register changes; LLB/LHB are ignored.
- R0 is hardwired to 0x0000:
  - Writes to DstReg=0 are discarded.
  - Reads of register 0 always return 0x0000.
- Reads are combinational: SrcDataN reflects reg[SrcRegN] with zero clock latency.
- Both read ports may address the same register at once; both return the same value.
- A write takes effect at the rising edge. Reads after that edge return the new value (one-cycle write-to-read latency without the optional bypass).
- X/undriven read specifiers produce undefined outputs; no check is required.
- Reset asserted mid-cycle overrides any pending write. Reset deasserting on the same edge as a write: the write is not taken.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. When WriteReg=1, DstReg!=0 and SrcRegN==DstReg, SrcDataN combinationally shows the value that will be stored at the next edge (the merged LLB/LHB/full-word result). The result is readable in the same cycle.
- Undefined: no forwarding. SrcDataN shows the stored value until the rising edge.
- After the edge, both variants read identical values.

Test Plan:
- Reset: assert rst, read all 16 registers -> each reads 0x0000; deassert and re-read -> still 0x0000.
- LLB write: WriteReg=1, LLB=1, DstReg=2, writedata=0xFFA5 after reset; next cycle SrcReg1=2 -> 0x00A5.
- Full and LHB writes:
  - WriteReg=1, LLB=0, LHB=0, DstReg=3, writedata=0xC130; then SrcReg2=3 -> 0xC130.
  - Then LHB=1, DstReg=3, writedata=0x0077 -> 0x7730.
- Overwrite while reading: reg2=0x00A5, reg3=0xC130; write DstReg=2, writedata=0x2570 with SrcReg1=2, SrcReg2=3.
  - After the edge: SrcData1=0x2570, SrcData2=0xC130.
  - With REGFILE_BYPASS_EN: SrcData1=0x2570 before the edge as well.
- R0: write 0xBEEF to DstReg=0 -> SrcReg1=0 reads 0x0000. WriteReg=0 with DstReg=5, writedata=0x1234 -> reg5 stays 0x0000.
- Async reset mid-operation: load reg4=0xAAAA, pulse rst between clock edges -> SrcData for reg4 reads 0x0000 immediately, before the next edge.

Source files
------------

// File: rtl/register_file.sv
// 16 x 16-bit CPU register file: two combinational read ports, one synchronous write port with LLB/LHB byte modes.
// Define REGFILE_BYPASS_EN to forward the pending write result to matching read ports in the same cycle.
module register_file #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SrcReg1,
    input  logic [ADDR_W-1:0] SrcReg2,
    input  logic [ADDR_W-1:0] DstReg,
    input  logic              WriteReg,
    input  logic [DATA_W-1:0] writedata,
    input  logic              LLB,
    input  logic              LHB,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] next_word;
    logic              write_en;

    // LLB wins over LHB; both byte modes keep the untouched bits of the old value.
    function automatic logic [DATA_W-1:0] merge_word(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] wdata,
        input logic              llb,
        input logic              lhb
    );
        logic [DATA_W-1:0] result;
        result = wdata;
        if (llb) begin
            result       = old_word;
            result[7:0]  = wdata[7:0];
        end else if (lhb) begin
            result       = old_word;
            result[15:8] = wdata[7:0];
        end
        return result;
    endfunction

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] sel);
        logic [DATA_W-1:0] value;
        value = (sel == '0) ? '0 : regs[sel];
`ifdef REGFILE_BYPASS_EN
        if (write_en && sel == DstReg)
            value = next_word;
`endif
        return value;
    endfunction

    assign write_en  = WriteReg && (DstReg != '0);
    assign next_word = merge_word(regs[DstReg], writedata, LLB, LHB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (write_en) begin
            regs[DstReg] <= next_word;
        end
    end

    always_comb begin
        SrcData1 = read_port(SrcReg1);
        SrcData2 = read_port(SrcReg2);
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, byte modes, R0, overwrite, async reset, back-to-back writes.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [3:0]  SrcReg1;
    logic [3:0]  SrcReg2;
    logic [3:0]  DstReg;
    logic        WriteReg;
    logic [15:0] writedata;
    logic        LLB;
    logic        LHB;
    logic [15:0] SrcData1;
    logic [15:0] SrcData2;

    int n_cmp  = 0;
    int n_fail = 0;

    register_file dut (
        .clk      (clk),
        .rst      (rst),
        .SrcReg1  (SrcReg1),
        .SrcReg2  (SrcReg2),
        .DstReg   (DstReg),
        .WriteReg (WriteReg),
        .writedata(writedata),
        .LLB      (LLB),
        .LHB      (LHB),
        .SrcData1 (SrcData1),
        .SrcData2 (SrcData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [3:0] dst, input logic [15:0] data,
                            input logic llb, input logic lhb);
        @(negedge clk);
        DstReg    = dst;
        writedata = data;
        LLB       = llb;
        LHB       = lhb;
        WriteReg  = 1'b1;
        @(posedge clk);
        #1;
        WriteReg  = 1'b0;
        LLB       = 1'b0;
        LHB       = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        for (int i = 0; i < 16; i++) begin
            SrcReg1 = 4'(i);
            SrcReg2 = 4'(15 - i);
            #1;
            if (SrcData1 !== 16'h0000) begin
                $display("FAIL reset_rd1 r%0d got %h want 0000", i, SrcData1); n_fail++;
            end
            n_cmp++;
            if (SrcData2 !== 16'h0000) begin
                $display("FAIL reset_rd2 r%0d got %h want 0000", 15 - i, SrcData2); n_fail++;
            end
            n_cmp++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            SrcReg1 = 4'(i);
            #1;
            if (SrcData1 !== 16'h0000) begin
                $display("FAIL post_reset r%0d got %h want 0000", i, SrcData1); n_fail++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_llb;
        do_write(4'd2, 16'hFFA5, 1'b1, 1'b0);
        SrcReg1 = 4'd2;
        #1;
        if (SrcData1 !== 16'h00A5) begin
            $display("FAIL llb_r2 got %h want 00a5", SrcData1); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_full_lhb;
        do_write(4'd3, 16'hC130, 1'b0, 1'b0);
        SrcReg2 = 4'd3;
        #1;
        if (SrcData2 !== 16'hC130) begin
            $display("FAIL full_r3 got %h want c130", SrcData2); n_fail++;
        end
        n_cmp++;
        do_write(4'd3, 16'h0077, 1'b0, 1'b1);
        #1;
        if (SrcData2 !== 16'h7730) begin
            $display("FAIL lhb_r3 got %h want 7730", SrcData2); n_fail++;
        end
        n_cmp++;
        do_write(4'd6, 16'h1234, 1'b0, 1'b0);
        do_write(4'd6, 16'hABCD, 1'b1, 1'b1);
        SrcReg1 = 4'd6;
        #1;
        if (SrcData1 !== 16'h12CD) begin
            $display("FAIL llb_priority_r6 got %h want 12cd", SrcData1); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_overwrite;
        logic [15:0] pre_exp;
        do_write(4'd3, 16'hC130, 1'b0, 1'b0);
`ifdef REGFILE_BYPASS_EN
        pre_exp = 16'h2570;
`else
        pre_exp = 16'h00A5;
`endif
        @(negedge clk);
        SrcReg1   = 4'd2;
        SrcReg2   = 4'd3;
        DstReg    = 4'd2;
        writedata = 16'h2570;
        WriteReg  = 1'b1;
        #1;
        if (SrcData1 !== pre_exp) begin
            $display("FAIL overwrite_pre_rd1 got %h want %h", SrcData1, pre_exp); n_fail++;
        end
        n_cmp++;
        if (SrcData2 !== 16'hC130) begin
            $display("FAIL overwrite_pre_rd2 got %h want c130", SrcData2); n_fail++;
        end
        n_cmp++;
        @(posedge clk);
        #1;
        WriteReg = 1'b0;
        #1;
        if (SrcData1 !== 16'h2570) begin
            $display("FAIL overwrite_post_rd1 got %h want 2570", SrcData1); n_fail++;
        end
        n_cmp++;
        if (SrcData2 !== 16'hC130) begin
            $display("FAIL overwrite_post_rd2 got %h want c130", SrcData2); n_fail++;
        end
        n_cmp++;
        SrcReg2 = 4'd2;
        #1;
        if (SrcData2 !== SrcData1 || SrcData2 !== 16'h2570) begin
            $display("FAIL same_reg_both_ports got %h/%h want 2570", SrcData1, SrcData2); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_r0;
        do_write(4'd0, 16'hBEEF, 1'b0, 1'b0);
        SrcReg1 = 4'd0;
        #1;
        if (SrcData1 !== 16'h0000) begin
            $display("FAIL r0_full_write got %h want 0000", SrcData1); n_fail++;
        end
        n_cmp++;
        do_write(4'd0, 16'h00EE, 1'b1, 1'b0);
        #1;
        if (SrcData1 !== 16'h0000) begin
            $display("FAIL r0_llb_write got %h want 0000", SrcData1); n_fail++;
        end
        n_cmp++;
        @(negedge clk);
        WriteReg  = 1'b0;
        DstReg    = 4'd5;
        writedata = 16'h1234;
        LLB       = 1'b1;
        LHB       = 1'b1;
        @(posedge clk);
        #1;
        LLB     = 1'b0;
        LHB     = 1'b0;
        SrcReg2 = 4'd5;
        #1;
        if (SrcData2 !== 16'h0000) begin
            $display("FAIL no_write_r5 got %h want 0000", SrcData2); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_async_reset;
        do_write(4'd4, 16'hAAAA, 1'b0, 1'b0);
        SrcReg1 = 4'd4;
        SrcReg2 = 4'd2;
        #1;
        if (SrcData1 !== 16'hAAAA) begin
            $display("FAIL r4_loaded got %h want aaaa", SrcData1); n_fail++;
        end
        n_cmp++;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        if (SrcData1 !== 16'h0000) begin
            $display("FAIL async_rst_r4 got %h want 0000", SrcData1); n_fail++;
        end
        n_cmp++;
        if (SrcData2 !== 16'h0000) begin
            $display("FAIL async_rst_r2 got %h want 0000", SrcData2); n_fail++;
        end
        n_cmp++;
        // reset held across an edge with a write pending: write must be dropped
        DstReg    = 4'd7;
        writedata = 16'h5555;
        WriteReg  = 1'b1;
        @(posedge clk);
        #2;
        rst      = 1'b0;
        WriteReg = 1'b0;
        SrcReg1  = 4'd7;
        #1;
        if (SrcData1 !== 16'h0000) begin
            $display("FAIL rst_blocks_write_r7 got %h want 0000", SrcData1); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        WriteReg  = 1'b1;
        DstReg    = 4'd8;
        writedata = 16'h1111;
        @(posedge clk);
        #1;
        DstReg    = 4'd9;
        writedata = 16'h2222;
        @(posedge clk);
        #1;
        DstReg    = 4'd8;
        writedata = 16'h0033;
        LHB       = 1'b1;
        @(posedge clk);
        #1;
        WriteReg  = 1'b0;
        LHB       = 1'b0;
        SrcReg1   = 4'd8;
        SrcReg2   = 4'd9;
        #1;
        if (SrcData1 !== 16'h3311) begin
            $display("FAIL b2b_r8 got %h want 3311", SrcData1); n_fail++;
        end
        n_cmp++;
        if (SrcData2 !== 16'h2222) begin
            $display("FAIL b2b_r9 got %h want 2222", SrcData2); n_fail++;
        end
        n_cmp++;
    endtask

    initial begin
        rst       = 1'b1;
        SrcReg1   = '0;
        SrcReg2   = '0;
        DstReg    = '0;
        WriteReg  = 1'b0;
        writedata = '0;
        LLB       = 1'b0;
        LHB       = 1'b0;
        test_reset();
        test_llb();
        test_full_lhb();
        test_overwrite();
        test_r0();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
